// File: rtl/diff_seq_ctrl.sv
// Run sequencer for the d-th order differencing stage: drives its control code,
// gates the sample stream, hides warm-up results. Optional run_cnt via DIFF_SEQ_STAT_EN.
module diff_seq_ctrl #(
   parameter int unsigned N     = 32,
   parameter int unsigned d_max = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic [N-1:0] d_order_cfg,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic [1:0]   diff_control,
   output logic [N-1:0] diff_data,
   output logic [N-1:0] diff_order,
   input  logic [N-1:0] diff_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         busy,
   output logic         err_cfg
`ifdef DIFF_SEQ_STAT_EN
   ,
   output logic [N-1:0] run_cnt
`endif
);

   localparam int unsigned  CntW = $clog2(d_max + 1);
   localparam logic [N-1:0] DMax = N'(d_max);

   localparam logic [1:0] CtrlWork  = 2'b00;
   localparam logic [1:0] CtrlStall = 2'b01;
   localparam logic [1:0] CtrlClear = 2'b11;

   typedef enum logic [2:0] {StIdle, StClear, StWarmup, StRun, StDrain} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    d_order_q, d_order_d;
   logic [CntW-1:0] warm_cnt_q, warm_cnt_d, warm_inc;
   logic            out_valid_q, out_valid_d;
   logic            err_cfg_q, err_cfg_d;
   logic            accept, take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         d_order_q   <= '0;
         warm_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         err_cfg_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_order_q   <= d_order_d;
         warm_cnt_q  <= warm_cnt_d;
         out_valid_q <= out_valid_d;
         err_cfg_q   <= err_cfg_d;
      end
   end

   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         StWarmup: in_ready = 1'b1;
         StRun:    in_ready = !out_valid_q || out_ready;
         default:  in_ready = 1'b0;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign take     = out_valid_q && out_ready;
   assign warm_inc = warm_cnt_q + CntW'(1);

   // diff_n only advances on an accept, so back-pressure freezes its history
   always_comb begin
      if (rst || state_q == StClear) begin
         diff_control = CtrlClear;
      end else if (accept) begin
         diff_control = CtrlWork;
      end else begin
         diff_control = CtrlStall;
      end
   end

   always_comb begin
      state_d    = state_q;
      d_order_d  = d_order_q;
      warm_cnt_d = warm_cnt_q;
      err_cfg_d  = 1'b0;

      out_valid_d = out_valid_q;
      if (take) begin
         out_valid_d = 1'b0;
      end
      if (accept && state_q == StRun) begin
         out_valid_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (d_order_cfg < DMax) begin
                  d_order_d = d_order_cfg;
                  state_d   = StClear;
               end else begin
                  err_cfg_d = 1'b1;
               end
            end
         end
         StClear: begin
            warm_cnt_d = '0;
            if (stop) begin
               state_d = StDrain;
            end else if (d_order_q == '0) begin
               state_d = StRun;
            end else begin
               state_d = StWarmup;
            end
         end
         StWarmup: begin
            if (accept) begin
               warm_cnt_d = warm_inc;
               if (N'(warm_inc) == d_order_q) begin
                  state_d = StRun;
               end
            end
            if (stop) begin
               state_d = StDrain;
            end
         end
         StRun: begin
            if (stop) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!out_valid_d) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef DIFF_SEQ_STAT_EN
   logic [N-1:0] run_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt_q <= '0;
      end else if (state_q == StClear) begin
         run_cnt_q <= '0;
      end else if (take && run_cnt_q != '1) begin
         run_cnt_q <= run_cnt_q + N'(1);
      end
   end

   assign run_cnt = run_cnt_q;
`endif

   assign diff_data  = in_data;
   assign diff_order = d_order_q;
   assign out_valid  = out_valid_q;
   assign out_data   = diff_out;
   assign busy       = (state_q != StIdle);
   assign err_cfg    = err_cfg_q;

endmodule

// File: tb/tb_diff_seq_ctrl.sv
// Bench for diff_seq_ctrl with a behavioural diff_n attached; outputs are checked
// against a binomial d-th difference of the accepted sample history.
module tb_diff_seq_ctrl;

   localparam int N    = 32;
   localparam int DMax = 10;

   typedef logic signed [N-1:0] sample_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [N-1:0] d_order_cfg = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] in_data = '0;
   logic [1:0]   diff_control;
   logic [N-1:0] diff_data;
   logic [N-1:0] diff_order;
   logic [N-1:0] diff_out;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] out_data;
   logic         busy;
   logic         err_cfg;
`ifdef DIFF_SEQ_STAT_EN
   logic [N-1:0] run_cnt;
`endif

   int checks = 0;
   int errors = 0;

   sample_t      hist[$];
   logic [N-1:0] sb[$];
   int           mon_order = 0;
   int           acc_cnt = 0;

   diff_seq_ctrl #(.N(N), .d_max(DMax)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .d_order_cfg  (d_order_cfg),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .diff_control (diff_control),
      .diff_data    (diff_data),
      .diff_order   (diff_order),
      .diff_out     (diff_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .busy         (busy),
      .err_cfg      (err_cfg)
`ifdef DIFF_SEQ_STAT_EN
      ,
      .run_cnt      (run_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural diff_n: cascade of first differences, registered output
   sample_t dreg [DMax];
   logic [N-1:0] stub_out;

   function automatic sample_t lvl(int k);
      sample_t v = sample_t'(diff_data);
      for (int j = 0; j < k; j++) v = v - dreg[j];
      return v;
   endfunction

   always @(posedge clk) begin
      if (diff_control == 2'b11) begin
         for (int k = 0; k < DMax; k++) dreg[k] <= '0;
         stub_out <= '0;
      end else if (diff_control == 2'b00) begin
         for (int k = 0; k < DMax; k++) begin
            if (k < int'(diff_order)) dreg[k] <= lvl(k);
         end
         stub_out <= lvl(int'(diff_order));
      end
   end
   assign diff_out = stub_out;

   // d-th difference as sum_k (-1)^k C(d,k) x[t-k], zeros before the run
   function automatic logic [N-1:0] ref_diff(int d);
      sample_t acc = '0;
      int      c = 1;
      int      n = hist.size();
      for (int k = 0; k <= d; k++) begin
         if (n - 1 - k >= 0) begin
            if (k % 2 == 1) acc = acc - sample_t'(c) * hist[n-1-k];
            else            acc = acc + sample_t'(c) * hist[n-1-k];
         end
         c = c * (d - k) / (k + 1);
      end
      return acc;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            hist.push_back(sample_t'(in_data));
            if (acc_cnt >= mon_order) sb.push_back(ref_diff(mon_order));
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got output %0h, required none", out_data);
            end else begin
               logic [N-1:0] exp_v;
               exp_v = sb.pop_front();
               if (out_data !== exp_v) begin
                  errors++;
                  $display("FAIL sb_data: got %0h, required %0h", out_data, exp_v);
               end
            end
         end
         checks++;
         if (diff_control === 2'b10) begin
            errors++;
            $display("FAIL ctrl_10: got %b, required not 10", diff_control);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int order);
      mon_order   = order;
      acc_cnt     = 0;
      hist.delete();
      d_order_cfg = N'(order);
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 20 && busy; i++) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: got busy %b, required 0", name, busy);
      end
   endtask

   task automatic check_sb_empty(input string name);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_sb_left: got %0d pending, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (diff_control !== 2'b11 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
          busy !== 1'b0 || err_cfg !== 1'b0 || diff_order !== '0) begin
         errors++;
         $display("FAIL reset_vals: got ctrl %b rdy %b ov %b busy %b err %b ord %0d, required 11 0 0 0 0 0",
                  diff_control, in_ready, out_valid, busy, err_cfg, diff_order);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (diff_control !== 2'b01 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got ctrl %b busy %b, required 01 0", diff_control, busy);
      end
   endtask

   task automatic test_warmup();
      do_start(2);
      checks++;
      if (diff_control !== 2'b11 || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL warm_clear: got ctrl %b busy %b rdy %b, required 11 1 0",
                  diff_control, busy, in_ready);
      end
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = N'((i + 1) * (i + 1));
         #1;
         checks++;
         if (in_ready !== 1'b1 || diff_control !== 2'b00) begin
            errors++;
            $display("FAIL warm_accept%0d: got rdy %b ctrl %b, required 1 00", i, in_ready, diff_control);
         end
         tick();
         checks++;
         if (out_valid !== (i >= 2)) begin
            errors++;
            $display("FAIL warm_valid%0d: got %b, required %b", i, out_valid, (i >= 2));
         end
      end
      in_valid = 1'b0;
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("warm");
      check_sb_empty("warm");
   endtask

   task automatic test_backpressure();
      do_start(1);
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'd10;
      tick();
      in_data = 32'd13;
      tick();
      out_ready = 1'b0;
      in_data   = 32'd20;
      #1;
      checks++;
      if (in_ready !== 1'b0 || diff_control !== 2'b01) begin
         errors++;
         $display("FAIL bp_gate: got rdy %b ctrl %b, required 0 01", in_ready, diff_control);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'd3 || in_ready !== 1'b0 ||
             diff_control !== 2'b01) begin
            errors++;
            $display("FAIL bp_hold%0d: got ov %b data %0d rdy %b ctrl %b, required 1 3 0 01",
                     i, out_valid, out_data, in_ready, diff_control);
         end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd7) begin
         errors++;
         $display("FAIL bp_release: got ov %b data %0d, required 1 7", out_valid, out_data);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: got ov %b, required 0", out_valid);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("bp");
      check_sb_empty("bp");
   endtask

   task automatic test_cfg_err();
      d_order_cfg = 32'd10;
      start       = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (err_cfg !== 1'b1 || busy !== 1'b0 || diff_control !== 2'b01 || diff_order !== 32'd1) begin
         errors++;
         $display("FAIL cfg_err: got err %b busy %b ctrl %b ord %0d, required 1 0 01 1",
                  err_cfg, busy, diff_control, diff_order);
      end
      tick();
      checks++;
      if (err_cfg !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL cfg_pulse: got err %b busy %b, required 0 0", err_cfg, busy);
      end
   endtask

   task automatic test_order0();
      stop = 1'b1;
      do_start(0);
      stop = 1'b0;
      checks++;
      if (busy !== 1'b1 || diff_control !== 2'b11) begin
         errors++;
         $display("FAIL o0_clear: got busy %b ctrl %b, required 1 11", busy, diff_control);
      end
      tick();
      checks++;
      if (diff_control !== 2'b01 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL o0_run: got ctrl %b rdy %b, required 01 1", diff_control, in_ready);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'd7;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd7) begin
         errors++;
         $display("FAIL o0_first: got ov %b data %0h, required 1 7", out_valid, out_data);
      end
      in_data = 32'hFFFF_FFFD;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFD) begin
         errors++;
         $display("FAIL o0_second: got ov %b data %0h, required 1 fffffffd", out_valid, out_data);
      end
      in_valid = 1'b0;
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("o0");
      check_sb_empty("o0");
   endtask

   task automatic test_reset_midrun();
      do_start(0);
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'd5;
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rm_pending: got ov %b, required 1", out_valid);
      end
      rst = 1'b1;
      #1;
      sb.delete();
      hist.delete();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || diff_control !== 2'b11 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rm_async: got ov %b rdy %b ctrl %b busy %b, required 0 0 11 0",
                  out_valid, in_ready, diff_control, busy);
      end
      tick();
      checks++;
      if (diff_control !== 2'b11) begin
         errors++;
         $display("FAIL rm_hold: got ctrl %b, required 11", diff_control);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || diff_control !== 2'b01 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_idle: got busy %b ctrl %b ov %b, required 0 01 0",
                  busy, diff_control, out_valid);
      end
   endtask

   task automatic test_drain();
      do_start(0);
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'd42;
      stop      = 1'b1;
      tick();
      stop     = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'd42 || in_ready !== 1'b0 ||
             diff_control !== 2'b01) begin
            errors++;
            $display("FAIL drain_hold%0d: got busy %b ov %b data %0d rdy %b ctrl %b, required 1 1 42 0 01",
                     i, busy, out_valid, out_data, in_ready, diff_control);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_exit: got busy %b ov %b, required 0 0", busy, out_valid);
      end
      check_sb_empty("drain");
   endtask

`ifdef DIFF_SEQ_STAT_EN
   task automatic test_stat();
      do_start(0);
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_data = N'(i * 3 + 1);
         tick();
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (run_cnt !== 32'd300) begin
         errors++;
         $display("FAIL stat_count: got %0d, required 300", run_cnt);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("stat");
      checks++;
      if (run_cnt !== 32'd300) begin
         errors++;
         $display("FAIL stat_keep: got %0d, required 300", run_cnt);
      end
      do_start(3);
      tick();
      checks++;
      if (run_cnt !== 32'd0) begin
         errors++;
         $display("FAIL stat_clear: got %0d, required 0", run_cnt);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("stat2");
      check_sb_empty("stat");
   endtask
`endif

   initial begin
      test_reset();
      test_warmup();
      test_backpressure();
      test_cfg_err();
      test_order0();
      test_reset_midrun();
      test_drain();
`ifdef DIFF_SEQ_STAT_EN
      test_stat();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
